// File: rtl/csr_access_arbiter_if.sv
// Request/response bundle between the core/host requesters and the CSR access arbiter.
// Handshake: a requester raises *_valid and holds it until its one-cycle *_ack pulse.
interface csr_access_arbiter_if #(
    parameter int size = 32
);
    logic            stall;
    logic            core_valid;
    logic [2:0]      core_funct3;
    logic [11:0]     core_addr;
    logic [size-1:0] core_rs1;
    logic [4:0]      core_zimm;
    logic            core_ack;
    logic            host_valid;
    logic [size-1:0] host_wdata;
    logic            host_ack;
    logic [size-1:0] csr_q;
    logic [size-1:0] csr_old;
    logic [7:0]      wr_count;
    logic [1:0]      state_dbg;

    modport master (
        output stall, core_valid, core_funct3, core_addr, core_rs1, core_zimm,
               host_valid, host_wdata,
        input  core_ack, host_ack, csr_q, csr_old, wr_count, state_dbg
    );

    modport slave (
        input  stall, core_valid, core_funct3, core_addr, core_rs1, core_zimm,
               host_valid, host_wdata,
        output core_ack, host_ack, csr_q, csr_old, wr_count, state_dbg
    );
endinterface

// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter between a core CSR instruction port and a host write port,
// serving one CSR register with RISC-V style RW/RS/RC (and immediate) updates.
module csr_access_arbiter #(
    parameter int          size     = 32,
    parameter logic [11:0] CSR_ADDR = 12'h51E
) (
    input logic clk,
    input logic rst,
    csr_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CORE_GNT = 2'd1, HOST_GNT = 2'd2} state_t;

    state_t          state;
    logic            last_grant;  // 1 = host was served last
    logic [2:0]      op_funct3;
    logic [11:0]     op_addr;
    logic [size-1:0] op_rs1;
    logic [4:0]      op_zimm;
    logic [size-1:0] host_data;
    logic [size-1:0] csr_q;
    logic [size-1:0] csr_old;
    logic [7:0]      wr_count;

    logic            core_elig;
    logic            host_elig;
    logic            pick_core;
    logic [size-1:0] operand;
    logic [size-1:0] core_new;
    logic            core_we;

    assign core_elig = bus.core_valid & ~bus.stall;
    assign host_elig = bus.host_valid;
    assign pick_core = core_elig & (~host_elig | last_grant);

    assign operand = op_funct3[2] ? {{(size-5){1'b0}}, op_zimm} : op_rs1;

    always_comb begin
        core_new = csr_q;
        case (op_funct3[1:0])
            2'b01:   core_new = operand;
            2'b10:   core_new = csr_q | operand;
            2'b11:   core_new = csr_q & ~operand;
            default: core_new = csr_q;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not count as a write.
    assign core_we = (op_addr == CSR_ADDR) && (op_funct3[1:0] != 2'b00) &&
                     !(op_funct3[1] && (operand == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_funct3  <= '0;
            op_addr    <= '0;
            op_rs1     <= '0;
            op_zimm    <= '0;
            host_data  <= '0;
            csr_q      <= '0;
            csr_old    <= '0;
            wr_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_core) begin
                        state      <= CORE_GNT;
                        last_grant <= 1'b0;
                        op_funct3  <= bus.core_funct3;
                        op_addr    <= bus.core_addr;
                        op_rs1     <= bus.core_rs1;
                        op_zimm    <= bus.core_zimm;
                    end else if (host_elig) begin
                        state      <= HOST_GNT;
                        last_grant <= 1'b1;
                        host_data  <= bus.host_wdata;
                    end
                end
                CORE_GNT: begin
                    if (!bus.stall) begin
                        state   <= IDLE;
                        csr_old <= csr_q;
                        if (core_we) begin
                            csr_q    <= core_new;
                            wr_count <= wr_count + 8'd1;
                        end
                    end
                end
                HOST_GNT: begin
                    state    <= IDLE;
                    csr_q    <= host_data;
                    wr_count <= wr_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Core ack follows stall within the grant cycle so the commit edge and the pulse line up.
    assign bus.core_ack  = (state == CORE_GNT) && !bus.stall;
    assign bus.host_ack  = (state == HOST_GNT);
    assign bus.csr_q     = csr_q;
    assign bus.csr_old   = csr_old;
    assign bus.wr_count  = wr_count;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: core ops, host writes, arbitration, stall and reset.
module tb_csr_access_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    csr_access_arbiter_if #(.size(32)) bus ();

    csr_access_arbiter #(.size(32), .CSR_ADDR(12'h51E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.stall       = 1'b0;
        bus.core_valid  = 1'b0;
        bus.core_funct3 = 3'b000;
        bus.core_addr   = 12'h000;
        bus.core_rs1    = '0;
        bus.core_zimm   = '0;
        bus.host_valid  = 1'b0;
        bus.host_wdata  = '0;
    endtask

    // Leaves the bench #1 after a rising edge with rst released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the commit edge.
    task automatic core_req(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                            input logic [31:0] rs1, input logic [4:0] zimm);
        bus.core_valid  = 1'b1;
        bus.core_funct3 = f3;
        bus.core_addr   = addr;
        bus.core_rs1    = rs1;
        bus.core_zimm   = zimm;
        @(posedge clk);
        #1;
        check({tag, "_core_ack"}, 32'(bus.core_ack), 32'd1);
        check({tag, "_host_ack"}, 32'(bus.host_ack), 32'd0);
        bus.core_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(bus.core_ack), 32'd0);
    endtask

    task automatic host_req(input string tag, input logic [31:0] wdata);
        bus.host_valid = 1'b1;
        bus.host_wdata = wdata;
        @(posedge clk);
        #1;
        check({tag, "_host_ack"}, 32'(bus.host_ack), 32'd1);
        bus.host_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] last_w;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        #2;
        check("rst_async_csr_q", bus.csr_q, 32'h0);
        check("rst_async_state", 32'(bus.state_dbg), 32'd0);
        do_reset();
        check("rst_csr_old", bus.csr_old, 32'h0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_acks", {30'd0, bus.core_ack, bus.host_ack}, 32'd0);

        // basic CSRRW
        core_req("rw", 3'b001, 12'h51E, 32'hDEADBEEF, 5'd0);
        check("rw_csr_q", bus.csr_q, 32'hDEADBEEF);
        check("rw_wr_count", 32'(bus.wr_count), 32'd1);
        check("rw_csr_old", bus.csr_old, 32'h0);

        host_req("seed", 32'hF0F0F0F0);
        check("seed_csr_q", bus.csr_q, 32'hF0F0F0F0);
        check("seed_wr_count", 32'(bus.wr_count), 32'd2);

        core_req("rsi", 3'b110, 12'h51E, 32'h0, 5'h0F);
        check("rsi_csr_q", bus.csr_q, 32'hF0F0F0FF);
        core_req("rc", 3'b011, 12'h51E, 32'h000000FF, 5'd0);
        check("rc_csr_q", bus.csr_q, 32'hF0F0F000);
        check("rc_csr_old", bus.csr_old, 32'hF0F0F0FF);
        check("rc_wr_count", 32'(bus.wr_count), 32'd4);

        // accesses that must not write
        core_req("badaddr", 3'b001, 12'h300, 32'h12121212, 5'd0);
        check("badaddr_csr_q", bus.csr_q, 32'hF0F0F000);
        check("badaddr_wr_count", 32'(bus.wr_count), 32'd4);
        core_req("rs_zero", 3'b010, 12'h51E, 32'h0, 5'd0);
        check("rs_zero_csr_q", bus.csr_q, 32'hF0F0F000);
        check("rs_zero_wr_count", 32'(bus.wr_count), 32'd4);
        core_req("f3_000", 3'b000, 12'h51E, 32'hFFFFFFFF, 5'd0);
        check("f3_000_csr_q", bus.csr_q, 32'hF0F0F000);
        core_req("rci_zero", 3'b111, 12'h51E, 32'hFFFFFFFF, 5'd0);
        check("rci_zero_wr_count", 32'(bus.wr_count), 32'd4);

        core_req("rwi", 3'b101, 12'h51E, 32'hFFFFFFFF, 5'd3);
        check("rwi_csr_q", bus.csr_q, 32'h00000003);
        check("rwi_wr_count", 32'(bus.wr_count), 32'd5);

        // stall while granted
        bus.core_valid  = 1'b1;
        bus.core_funct3 = 3'b001;
        bus.core_addr   = 12'h51E;
        bus.core_rs1    = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        #1;
        check("stall_state", 32'(bus.state_dbg), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_no_ack", 32'(bus.core_ack), 32'd0);
            check("stall_csr_q", bus.csr_q, 32'h00000003);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_ack", 32'(bus.core_ack), 32'd1);
        bus.core_valid = 1'b0;
        @(posedge clk);
        #1;
        check("unstall_csr_q", bus.csr_q, 32'hA5A5A5A5);
        check("unstall_wr_count", 32'(bus.wr_count), 32'd6);

        // simultaneous requests from reset: core first, then host
        do_reset();
        bus.core_valid  = 1'b1;
        bus.core_funct3 = 3'b001;
        bus.core_addr   = 12'h51E;
        bus.core_rs1    = 32'h11111111;
        bus.host_valid  = 1'b1;
        bus.host_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        check("both_core_ack", {30'd0, bus.core_ack, bus.host_ack}, 32'd2);
        bus.core_valid = 1'b0;
        @(posedge clk);
        #1;
        check("both_gap_acks", {30'd0, bus.core_ack, bus.host_ack}, 32'd0);
        check("both_mid_csr_q", bus.csr_q, 32'h11111111);
        @(posedge clk);
        #1;
        check("both_host_ack", {30'd0, bus.core_ack, bus.host_ack}, 32'd1);
        bus.host_valid = 1'b0;
        @(posedge clk);
        #1;
        check("both_csr_q", bus.csr_q, 32'h12345678);
        check("both_wr_count", 32'(bus.wr_count), 32'd2);

        // wr_count wrap over 256 host writes
        do_reset();
        last_w = '0;
        for (int i = 0; i < 256; i++) begin
            last_w = $urandom_range(32'hFFFF, 1) * 32'h10001;
            host_req("wrap", last_w);
        end
        check("wrap_wr_count", 32'(bus.wr_count), 32'd0);
        check("wrap_csr_q", bus.csr_q, last_w);

        // reset in the middle of a host grant
        bus.host_valid = 1'b1;
        bus.host_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("midrst_granted", 32'(bus.host_ack), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_host_ack", 32'(bus.host_ack), 32'd0);
        check("midrst_csr_q", bus.csr_q, 32'h0);
        check("midrst_wr_count", 32'(bus.wr_count), 32'd0);
        bus.host_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_after_csr_q", bus.csr_q, 32'h0);
        check("midrst_after_acks", {30'd0, bus.core_ack, bus.host_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Acks must never overlap.
    always @(negedge clk) begin
        if (bus.core_ack && bus.host_ack) begin
            check("ack_overlap", 32'd1, 32'd0);
        end
    end
endmodule
